reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised, scoreboarded register file for the venus core. It holds `DEPTH` architectural registers of `WIDTH` bits with `NREAD` combinational read ports, one reservation port and one writeback port. Each register carries a busy bit and a reservation tag, so a late writeback from an older producer cannot clobber a newer reservation of the same register. It sits between decode/issue, which reads and reserves, and the writeback stage, and supports a global flush on pipeline squash.

## Interface
Parameters:
- `WIDTH`, 32, data width per register
- `DEPTH`, 32, number of registers; `AW = $clog2(DEPTH)`
- `NREAD`, 2, number of read ports
- `TAG_W`, 4, reservation tag width
- `ZERO_REG`, 1, when 1, register 0 is hardwired to zero and never busy

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous and active-high
- `rd_addr_i`  in  NREAD*AW  read addresses, packed with port 0 in the LSBs
- `rd_data_o`  out  NREAD*WIDTH  read data, with bypass
- `rd_busy_o`  out  NREAD  register is reserved
- `rd_tag_o`  out  NREAD*TAG_W  current reservation tag of the addressed register
- `res_valid_i`  in  1  reserve request
- `res_addr_i`  in  AW  register to reserve
- `res_tag_i`  in  TAG_W  tag of the new producer
- `wb_valid_i`  in  1  writeback request
- `wb_addr_i`  in  AW  writeback register
- `wb_tag_i`  in  TAG_W  tag of the writing producer
- `wb_data_i`  in  WIDTH  writeback data
- `wb_stale_o`  out  1  registered pulse: the previous cycle's writeback was dropped
- `flush_i`  in  1  clear all reservations
- `busy_cnt_o`  out  $clog2(DEPTH+1)  number of busy registers

## Operation
- Per register state: `data`, `busy`, `tag`.
- Writeback acceptance: `wb_valid_i & (!busy[a] | tag[a]==wb_tag_i)`. Accepted means data is written and busy is cleared. Not accepted (stale) means no state change, and `wb_stale_o` is 1 in the next cycle.
- Reservation: `busy[a]` is set to 1 and `tag[a]` to `res_tag_i`. Re-reserving an already busy register overwrites the tag; the older producer then becomes stale.
- Reservation and accepted writeback to the same register in the same cycle: data is written, and the register ends busy with the new tag. Reserve wins on busy.
- Flush: all `busy` and `tag` are cleared to 0, and a concurrent reservation is ignored. A concurrent writeback is still evaluated against pre-flush state; if accepted, its data is written.
- `ZERO_REG=1`: reservations and writebacks to address 0 are ignored, with no stale pulse. Reads of address 0 return 0, not busy, tag 0.
- Addresses `>= DEPTH` (when DEPTH is not a power of 2): reads return 0 and not busy; reservations and writebacks are ignored.
- `busy_cnt_o` is a registered counter tracking the popcount of `busy`. It is updated incrementally (+1 / −1 / 0 per cycle, or reset to 0 on flush). It is not recomputed by popcount.

## Timing
- Reads are combinational from current state, with writeback bypass. If the writeback in the same cycle is accepted and its address matches, `rd_data_o` returns `wb_data_i` and `rd_busy_o` returns 0.
- Reads do not see a same-cycle reservation: the reserving instruction reads its sources first.
- State updates on the `clk` edge; a reservation is visible to reads from the next cycle.
- Reset (synchronous, `rst=1`): all data is 0, all busy bits 0, all tags 0. Reset values of outputs: `wb_stale_o=0`, `busy_cnt_o=0`, `rd_busy_o` all 0, `rd_data_o` all 0 (for any address). Reset overrides flush, reservation and writeback in the same cycle.
- Latency: writeback to visible data is 0 cycles via bypass and 1 cycle via storage. `wb_stale_o` lags the writeback by 1 cycle.

## Structure
- Shared package `venus_pkg`: `WORD`, the default tag width, and a `sb_entry_t` struct (busy, tag).
- One natural sub-module, `reg_file_sb_cell`: a single register plus busy bit and tag, with reserve/writeback/flush inputs. It is instantiated `DEPTH` times in a generate loop. The top level contains only address decode, the read muxes with bypass, the stale flag and the counter.

## Test plan
- Reset, then read all addresses → data 0, busy 0, `busy_cnt_o=0`.
- Reserve r5 with tag 3; next cycle read r5 → busy 1, tag 3, `busy_cnt_o=1`. Writeback r5 with tag 3 and data 0xDEADBEEF → same-cycle read gives 0xDEADBEEF and not busy; next cycle busy 0 and count 0.
- WAW: reserve r7 with tag 1, then reserve r7 with tag 2. Writeback r7 with tag 1 and data 0x11 → dropped, `wb_stale_o=1` next cycle, r7 still busy with tag 2. Writeback with tag 2 and data 0x22 → r7 = 0x22.
- Reserve r9 with tag 4 and writeback r9 (tag matching an earlier tag 2 reservation, data 0x55) in the same cycle → r9 = 0x55, busy, tag 4, count unchanged.
- Reserve r1, r2, r3 (count 3), then flush together with a reservation of r4 → count 0, no register busy, r4 not reserved.
- `ZERO_REG=1`: reserve r0 and writeback r0 with 0xFFFF → r0 reads 0 and not busy, no stale pulse, count 0.

Source files
------------

// File: rtl/venus_pkg.sv
// Shared venus core types: default word and tag widths plus the scoreboard entry layout.
package venus_pkg;

    localparam int WORD      = 32;
    localparam int TAG_W_DEF = 4;

    typedef struct packed {
        logic                 busy;
        logic [TAG_W_DEF-1:0] tag;
    } sb_entry_t;

endpackage

// File: rtl/reg_file_sb_cell.sv
// One architectural register with its scoreboard busy bit and reservation tag.
module reg_file_sb_cell
    import venus_pkg::*;
#(
    parameter int WIDTH = WORD,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_res,
    input  logic [TAG_W-1:0] i_res_tag,
    input  logic             i_wb,
    input  logic [WIDTH-1:0] i_wb_data,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_data,
    output logic             o_busy,
    output logic [TAG_W-1:0] o_tag
);

    logic [WIDTH-1:0] r_data;
    logic             r_busy;
    logic [TAG_W-1:0] r_tag;

    // Flush beats reserve, and reserve beats writeback on the busy bit; data still lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_busy <= 1'b0;
            r_tag  <= '0;
        end else begin
            if (i_wb) begin
                r_data <= i_wb_data;
            end
            if (i_flush) begin
                r_busy <= 1'b0;
                r_tag  <= '0;
            end else if (i_res) begin
                r_busy <= 1'b1;
                r_tag  <= i_res_tag;
            end else if (i_wb) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_data = r_data;
    assign o_busy = r_busy;
    assign o_tag  = r_tag;

endmodule

// File: rtl/reg_file_sb.sv
// Scoreboarded register file: address decode, bypassed read muxes, stale-writeback flag, busy counter.
module reg_file_sb
    import venus_pkg::*;
#(
    parameter int WIDTH    = WORD,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int TAG_W    = TAG_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(DEPTH),
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREAD*AW-1:0]    rd_addr_i,
    output logic [NREAD*WIDTH-1:0] rd_data_o,
    output logic [NREAD-1:0]       rd_busy_o,
    output logic [NREAD*TAG_W-1:0] rd_tag_o,
    input  logic                   res_valid_i,
    input  logic [AW-1:0]          res_addr_i,
    input  logic [TAG_W-1:0]       res_tag_i,
    input  logic                   wb_valid_i,
    input  logic [AW-1:0]          wb_addr_i,
    input  logic [TAG_W-1:0]       wb_tag_i,
    input  logic [WIDTH-1:0]       wb_data_i,
    output logic                   wb_stale_o,
    input  logic                   flush_i,
    output logic [CW-1:0]          busy_cnt_o
);

    logic [WIDTH-1:0] w_data [DEPTH];
    logic [TAG_W-1:0] w_tag  [DEPTH];
    logic [DEPTH-1:0] w_busy;

    logic             w_wb_in, w_wb_busy, w_res_in, w_res_busy;
    logic [TAG_W-1:0] w_wb_tag;
    logic             w_wb_hit, w_wb_acc, w_res_eff, w_inc, w_dec;
    logic             r_stale;
    logic [CW-1:0]    r_cnt;

    // An address is "in" when it names a real, writable register (not r0 when hardwired).
    always_comb begin
        w_wb_in    = 1'b0;
        w_wb_busy  = 1'b0;
        w_wb_tag   = '0;
        w_res_in   = 1'b0;
        w_res_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wb_addr_i == AW'(i)) begin
                w_wb_in   = !(ZERO_REG != 0 && i == 0);
                w_wb_busy = w_busy[i];
                w_wb_tag  = w_tag[i];
            end
            if (res_addr_i == AW'(i)) begin
                w_res_in   = !(ZERO_REG != 0 && i == 0);
                w_res_busy = w_busy[i];
            end
        end
    end

    assign w_wb_hit  = wb_valid_i & w_wb_in & !rst;
    assign w_wb_acc  = w_wb_hit & (!w_wb_busy | (w_wb_tag == wb_tag_i));
    assign w_res_eff = res_valid_i & w_res_in & !flush_i & !rst;

    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        reg_file_sb_cell #(
            .WIDTH(WIDTH),
            .TAG_W(TAG_W)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .i_res    (w_res_eff & (res_addr_i == AW'(g))),
            .i_res_tag(res_tag_i),
            .i_wb     (w_wb_acc & (wb_addr_i == AW'(g))),
            .i_wb_data(wb_data_i),
            .i_flush  (flush_i),
            .o_data   (w_data[g]),
            .o_busy   (w_busy[g]),
            .o_tag    (w_tag[g])
        );
    end

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        rd_tag_o  = '0;
        for (int p = 0; p < NREAD; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_addr_i[p*AW +: AW] == AW'(i) && !(ZERO_REG != 0 && i == 0)) begin
                    rd_data_o[p*WIDTH +: WIDTH] = w_data[i];
                    rd_busy_o[p]                = w_busy[i];
                    rd_tag_o[p*TAG_W +: TAG_W]  = w_tag[i];
                end
            end
            if (w_wb_acc && rd_addr_i[p*AW +: AW] == wb_addr_i) begin
                rd_data_o[p*WIDTH +: WIDTH] = wb_data_i;
                rd_busy_o[p]                = 1'b0;
            end
        end
    end

    // A same-register reserve keeps the entry busy, so the writeback does not retire it.
    assign w_inc = w_res_eff & !w_res_busy;
    assign w_dec = w_wb_acc & w_wb_busy & !(w_res_eff && res_addr_i == wb_addr_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stale <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_stale <= w_wb_hit & !w_wb_acc;
            if (flush_i) begin
                r_cnt <= '0;
            end else if (w_inc && !w_dec) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (!w_inc && w_dec) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign wb_stale_o = r_stale;
    assign busy_cnt_o = r_cnt;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: vector table plus hand sequences for reset, scoreboard readback and mid-run reset.
module tb_reg_file_sb;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int NREAD = 2;
    localparam int TAG_W = 4;
    localparam int AW    = 5;
    localparam int CW    = 6;

    logic                   clk;
    logic                   rst;
    logic [NREAD*AW-1:0]    rd_addr_i;
    logic [NREAD*WIDTH-1:0] rd_data_o;
    logic [NREAD-1:0]       rd_busy_o;
    logic [NREAD*TAG_W-1:0] rd_tag_o;
    logic                   res_valid_i;
    logic [AW-1:0]          res_addr_i;
    logic [TAG_W-1:0]       res_tag_i;
    logic                   wb_valid_i;
    logic [AW-1:0]          wb_addr_i;
    logic [TAG_W-1:0]       wb_tag_i;
    logic [WIDTH-1:0]       wb_data_i;
    logic                   wb_stale_o;
    logic                   flush_i;
    logic [CW-1:0]          busy_cnt_o;

    reg_file_sb #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD), .TAG_W(TAG_W), .ZERO_REG(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .rd_busy_o  (rd_busy_o),
        .rd_tag_o   (rd_tag_o),
        .res_valid_i(res_valid_i),
        .res_addr_i (res_addr_i),
        .res_tag_i  (res_tag_i),
        .wb_valid_i (wb_valid_i),
        .wb_addr_i  (wb_addr_i),
        .wb_tag_i   (wb_tag_i),
        .wb_data_i  (wb_data_i),
        .wb_stale_o (wb_stale_o),
        .flush_i    (flush_i),
        .busy_cnt_o (busy_cnt_o)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [WIDTH-1:0] exp_q[$];

    typedef struct {
        logic        res_v;
        logic [4:0]  res_a;
        logic [3:0]  res_t;
        logic        wb_v;
        logic [4:0]  wb_a;
        logic [3:0]  wb_t;
        logic [31:0] wb_d;
        logic        flush;
        logic [4:0]  rd_a;
        logic [31:0] e_data;
        logic        e_busy;
        logic        chk_tag;
        logic [3:0]  e_tag;
        logic        e_stale;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        res_valid_i = 1'b0;
        res_addr_i  = '0;
        res_tag_i   = '0;
        wb_valid_i  = 1'b0;
        wb_addr_i   = '0;
        wb_tag_i    = '0;
        wb_data_i   = '0;
        flush_i     = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_both(input logic [4:0] a);
        rd_addr_i = {a, a};
        #1;
    endtask

    task automatic add(input logic rv, input logic [4:0] ra, input logic [3:0] rt,
                       input logic wv, input logic [4:0] wa, input logic [3:0] wt, input logic [31:0] wd,
                       input logic fl, input logic [4:0] rda,
                       input logic [31:0] ed, input logic eb, input logic ct, input logic [3:0] et,
                       input logic es, input logic [5:0] ec);
        vec_t v;
        v.res_v = rv; v.res_a = ra; v.res_t = rt;
        v.wb_v = wv; v.wb_a = wa; v.wb_t = wt; v.wb_d = wd;
        v.flush = fl; v.rd_a = rda;
        v.e_data = ed; v.e_busy = eb; v.chk_tag = ct; v.e_tag = et;
        v.e_stale = es; v.e_cnt = ec;
        vecs.push_back(v);
    endtask

    initial begin
        //  res      addr tag   wb     addr tag  data          fl  rd     data          busy ctag tag  stale cnt
        add(0, 0, 0,       0, 0, 0, 32'h0,           0, 0,      32'h0,          0, 1, 0,  0, 0); // idle r0
        add(0, 0, 0,       0, 0, 0, 32'h0,           0, 31,     32'h0,          0, 1, 0,  0, 0); // idle r31
        add(1, 5, 3,       0, 0, 0, 32'h0,           0, 5,      32'h0,          0, 1, 0,  0, 1); // reserve r5, read blind to it
        add(0, 0, 0,       0, 0, 0, 32'h0,           0, 5,      32'h0,          1, 1, 3,  0, 1); // r5 busy tag 3
        add(0, 0, 0,       1, 5, 3, 32'hDEADBEEF,    0, 5,      32'hDEADBEEF,   0, 0, 0,  0, 0); // bypass
        add(0, 0, 0,       0, 0, 0, 32'h0,           0, 5,      32'hDEADBEEF,   0, 0, 0,  0, 0); // stored
        add(1, 7, 1,       0, 0, 0, 32'h0,           0, 7,      32'h0,          0, 1, 0,  0, 1);
        add(1, 7, 2,       0, 0, 0, 32'h0,           0, 7,      32'h0,          1, 1, 1,  0, 1); // re-reserve
        add(0, 0, 0,       1, 7, 1, 32'h11,          0, 7,      32'h0,          1, 1, 2,  1, 1); // stale wb
        add(0, 0, 0,       0, 0, 0, 32'h0,           0, 7,      32'h0,          1, 1, 2,  0, 1);
        add(0, 0, 0,       1, 7, 2, 32'h22,          0, 7,      32'h22,         0, 0, 0,  0, 0);
        add(0, 0, 0,       0, 0, 0, 32'h0,           0, 7,      32'h22,         0, 0, 0,  0, 0);
        add(1, 9, 2,       0, 0, 0, 32'h0,           0, 9,      32'h0,          0, 1, 0,  0, 1);
        add(1, 9, 4,       1, 9, 2, 32'h55,          0, 9,      32'h55,         0, 0, 0,  0, 1); // reserve + wb
        add(0, 0, 0,       0, 0, 0, 32'h0,           0, 9,      32'h55,         1, 1, 4,  0, 1);
        add(0, 0, 0,       1, 9, 4, 32'h66,          0, 9,      32'h66,         0, 0, 0,  0, 0);
        add(1, 1, 1,       0, 0, 0, 32'h0,           0, 1,      32'h0,          0, 1, 0,  0, 1);
        add(1, 2, 2,       0, 0, 0, 32'h0,           0, 1,      32'h0,          1, 1, 1,  0, 2);
        add(1, 3, 3,       0, 0, 0, 32'h0,           0, 2,      32'h0,          1, 1, 2,  0, 3);
        add(1, 4, 5,       0, 0, 0, 32'h0,           1, 3,      32'h0,          1, 1, 3,  0, 0); // flush + res
        add(0, 0, 0,       0, 0, 0, 32'h0,           0, 4,      32'h0,          0, 1, 0,  0, 0);
        add(0, 0, 0,       0, 0, 0, 32'h0,           0, 3,      32'h0,          0, 1, 0,  0, 0);
        add(1, 0, 6,       1, 0, 0, 32'hFFFF,        0, 0,      32'h0,          0, 1, 0,  0, 0); // r0 hardwired
        add(0, 0, 0,       0, 0, 0, 32'h0,           0, 0,      32'h0,          0, 1, 0,  0, 0);
        add(0, 0, 0,       1, 0, 1, 32'hFFFF,        0, 0,      32'h0,          0, 1, 0,  0, 0);
        add(1, 10, 1,      0, 0, 0, 32'h0,           0, 10,     32'h0,          0, 1, 0,  0, 1);
        add(0, 0, 0,       1, 10, 1, 32'hABCD,       1, 10,     32'hABCD,       0, 0, 0,  0, 0); // flush + wb
        add(0, 0, 0,       0, 0, 0, 32'h0,           0, 10,     32'hABCD,       0, 1, 0,  0, 0);
        add(0, 0, 0,       1, 12, 9, 32'h1234,       0, 12,     32'h1234,       0, 0, 0,  0, 0); // wb, never reserved
        add(0, 0, 0,       0, 0, 0, 32'h0,           0, 12,     32'h1234,       0, 0, 0,  0, 0);
    end

    initial begin
        rst = 1'b1;
        rd_addr_i = '0;
        drive_idle();
        step();
        step();
        rst = 1'b0;

        // Reset state across every address
        for (int a = 0; a < DEPTH; a++) begin
            read_both(5'(a));
            chk($sformatf("rst_data0_r%0d", a), rd_data_o[31:0], 32'h0);
            chk($sformatf("rst_data1_r%0d", a), rd_data_o[63:32], 32'h0);
            chk($sformatf("rst_busy_r%0d", a), {30'h0, rd_busy_o}, 32'h0);
        end
        chk("rst_cnt", {26'h0, busy_cnt_o}, 32'h0);
        chk("rst_stale", {31'h0, wb_stale_o}, 32'h0);

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            res_valid_i = vecs[i].res_v;
            res_addr_i  = vecs[i].res_a;
            res_tag_i   = vecs[i].res_t;
            wb_valid_i  = vecs[i].wb_v;
            wb_addr_i   = vecs[i].wb_a;
            wb_tag_i    = vecs[i].wb_t;
            wb_data_i   = vecs[i].wb_d;
            flush_i     = vecs[i].flush;
            rd_addr_i   = {vecs[i].rd_a, vecs[i].rd_a};
            #2;
            for (int p = 0; p < NREAD; p++) begin
                chk($sformatf("v%0d_data_p%0d", i, p), rd_data_o[p*WIDTH +: WIDTH], vecs[i].e_data);
                chk($sformatf("v%0d_busy_p%0d", i, p), {31'h0, rd_busy_o[p]}, {31'h0, vecs[i].e_busy});
                if (vecs[i].chk_tag)
                    chk($sformatf("v%0d_tag_p%0d", i, p), {28'h0, rd_tag_o[p*TAG_W +: TAG_W]}, {28'h0, vecs[i].e_tag});
            end
            step();
            chk($sformatf("v%0d_stale", i), {31'h0, wb_stale_o}, {31'h0, vecs[i].e_stale});
            chk($sformatf("v%0d_cnt", i), {26'h0, busy_cnt_o}, {26'h0, vecs[i].e_cnt});
        end
        drive_idle();

        // Scoreboard readback: storage path through read port 1 only
        for (int k = 0; k < 4; k++) begin
            wb_valid_i = 1'b1;
            wb_addr_i  = 5'(16 + k);
            wb_tag_i   = 4'(k);
            wb_data_i  = 32'hC0DE_0000 | (32'(k) * 32'h1111);
            exp_q.push_back(wb_data_i);
            step();
        end
        drive_idle();
        for (int k = 0; k < 4; k++) begin
            logic [WIDTH-1:0] e;
            rd_addr_i = {5'(16 + k), 5'd0};
            #1;
            e = exp_q.pop_front();
            chk($sformatf("sb_r%0d_p1", 16 + k), rd_data_o[63:32], e);
            chk($sformatf("sb_r%0d_p0_r0", 16 + k), rd_data_o[31:0], 32'h0);
        end

        // Mid-run reset overrides concurrent reserve and writeback
        res_valid_i = 1'b1; res_addr_i = 5'd20; res_tag_i = 4'd7;
        step();
        drive_idle();
        read_both(5'd20);
        chk("pre_rst_busy", {30'h0, rd_busy_o}, 32'h3);
        chk("pre_rst_cnt", {26'h0, busy_cnt_o}, 32'h1);
        rst = 1'b1;
        res_valid_i = 1'b1; res_addr_i = 5'd21; res_tag_i = 4'd1;
        wb_valid_i = 1'b1; wb_addr_i = 5'd20; wb_tag_i = 4'd7; wb_data_i = 32'h77;
        step();
        rst = 1'b0;
        drive_idle();
        read_both(5'd20);
        chk("post_rst_r20_data", rd_data_o[31:0], 32'h0);
        chk("post_rst_r20_busy", {30'h0, rd_busy_o}, 32'h0);
        read_both(5'd21);
        chk("post_rst_r21_busy", {30'h0, rd_busy_o}, 32'h0);
        read_both(5'd16);
        chk("post_rst_r16_data", rd_data_o[63:32], 32'h0);
        chk("post_rst_cnt", {26'h0, busy_cnt_o}, 32'h0);
        chk("post_rst_stale", {31'h0, wb_stale_o}, 32'h0);

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
